// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/branch controller for the program counter.
//
// Sequences each instruction as FETCH (request at pc, wait for ack, increment PC)
// followed by EXEC (wait for execDone, then apply ret/call/jmp). It drives the PC's
// enable/load/inAddr inputs and owns a small hardware return-address stack.
//
// Configuration macro: RA8_PCSEQ_RETSTACK_EN
//   defined   - return-address stack built; call pushes, ret pops, and an
//               overflow/underflow sets stackErr and parks the sequencer in HALT.
//   undefined - no stack; call acts as jmp, ret is ignored, stackErr/stackDepth are 0.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   run                   permits starting new fetches
//   pc                    current program counter value
//   pcEnable/pcLoad       increment / load strobes to the PC
//   pcInAddr              load address (0 when pcLoad=0)
//   fetchReq/fetchAddr    instruction fetch request and address (address 0 when idle)
//   fetchAck              memory acknowledge
//   execDone              execute stage finished the current instruction
//   jmp/call/ret/target   control-flow request, sampled with execDone
//   halted                sequencer is in HALT
//   stackErr              sticky stack overflow/underflow flag
//   stackDepth            number of valid return-address stack entries
module pc_sequencer #(
    parameter int unsigned       ADDR_W      = 16,
    parameter int unsigned       STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             run,
    input  logic [ADDR_W-1:0]                pc,
    output logic                             pcEnable,
    output logic                             pcLoad,
    output logic [ADDR_W-1:0]                pcInAddr,
    output logic                             fetchReq,
    output logic [ADDR_W-1:0]                fetchAddr,
    input  logic                             fetchAck,
    input  logic                             execDone,
    input  logic                             jmp,
    input  logic                             call,
    input  logic                             ret,
    input  logic [ADDR_W-1:0]                target,
    output logic                             halted,
    output logic                             stackErr,
    output logic [$clog2(STACK_DEPTH+1)-1:0] stackDepth
);

    localparam int unsigned DW = $clog2(STACK_DEPTH + 1);

    typedef enum logic [2:0] {StBoot, StIdle, StFetch, StExec, StHalt} state_e;

    state_e state_q, state_d;

`ifdef RA8_PCSEQ_RETSTACK_EN
    localparam int unsigned IW = $clog2(STACK_DEPTH);

    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
    logic [DW-1:0]     depth_q;
    logic              err_q;
    logic              push, pop, err_set;
    logic              stack_empty, stack_full;
    logic [IW-1:0]     push_idx, pop_idx;

    assign stack_empty = (depth_q == '0);
    assign stack_full  = (depth_q == DW'(STACK_DEPTH));
    assign push_idx    = depth_q[IW-1:0];
    assign pop_idx     = IW'(depth_q - DW'(1));
    assign stackDepth  = depth_q;
    assign stackErr    = err_q;
`else
    logic unused_ret;
    assign unused_ret = ret;
    assign stackDepth = '0;
    assign stackErr   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StBoot;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pcEnable  = 1'b0;
        pcLoad    = 1'b0;
        pcInAddr  = '0;
        fetchReq  = 1'b0;
        fetchAddr = '0;
        halted    = 1'b0;
`ifdef RA8_PCSEQ_RETSTACK_EN
        push      = 1'b0;
        pop       = 1'b0;
        err_set   = 1'b0;
`endif
        unique case (state_q)
            StBoot: begin
                pcLoad   = 1'b1;
                pcInAddr = RESET_VEC;
                state_d  = StIdle;
            end
            StIdle: begin
                if (run) state_d = StFetch;
            end
            StFetch: begin
                fetchReq  = 1'b1;
                fetchAddr = pc;
                if (fetchAck) begin
                    pcEnable = 1'b1;
                    state_d  = StExec;
                end
            end
            StExec: begin
                if (execDone) begin
                    state_d = run ? StFetch : StIdle;
`ifdef RA8_PCSEQ_RETSTACK_EN
                    // ret > call > jmp; a stack fault suppresses the load entirely
                    if (ret) begin
                        if (stack_empty) begin
                            err_set = 1'b1;
                            state_d = StHalt;
                        end else begin
                            pop      = 1'b1;
                            pcLoad   = 1'b1;
                            pcInAddr = stack_q[pop_idx];
                        end
                    end else if (call) begin
                        if (stack_full) begin
                            err_set = 1'b1;
                            state_d = StHalt;
                        end else begin
                            // pc already holds the return address after the fetch increment
                            push     = 1'b1;
                            pcLoad   = 1'b1;
                            pcInAddr = target;
                        end
                    end else if (jmp) begin
                        pcLoad   = 1'b1;
                        pcInAddr = target;
                    end
`else
                    if (call || jmp) begin
                        pcLoad   = 1'b1;
                        pcInAddr = target;
                    end
`endif
                end
            end
            StHalt: begin
                halted = 1'b1;
            end
            default: begin
                state_d = StBoot;
            end
        endcase
    end

`ifdef RA8_PCSEQ_RETSTACK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (push) depth_q <= depth_q + DW'(1);
            if (pop)  depth_q <= depth_q - DW'(1);
            if (err_set) err_q <= 1'b1;
        end
    end

    // Storage needs no reset: entries are only read below depth_q.
    always_ff @(posedge clk) begin
        if (push) stack_q[push_idx] <= pc;
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam int ADDR_W      = 16;
    localparam int STACK_DEPTH = 4;
    localparam logic [15:0] RESET_VEC = 16'h0000;

    localparam int PH_BOOT  = 0;
    localparam int PH_IDLE  = 1;
    localparam int PH_FETCH = 2;
    localparam int PH_EXEC  = 3;
    localparam int PH_HALT  = 4;

    logic        clk = 1'b0;
    logic        reset, run, fetchAck, execDone, jmp, call, ret;
    logic [15:0] pc, target;
    logic        pcEnable, pcLoad, fetchReq, halted, stackErr;
    logic [15:0] pcInAddr, fetchAddr;
    logic [2:0]  stackDepth;

    int checks = 0;
    int errors = 0;

    // Reference: program counter plus instruction-cycle model
    int          m_phase = PH_BOOT;
    int          m_depth = 0;
    logic        m_err   = 1'b0;
    logic        m_valid = 1'b0;
    logic [15:0] m_pc    = 16'h0000;
    logic [15:0] m_stk [0:STACK_DEPTH-1];

    logic        exp_en, exp_load, exp_req, exp_halt;
    logic [15:0] exp_in, exp_faddr;

    int en_total  = 0;
    int req_total = 0;

    assign pc = m_pc;

    pc_sequencer #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH),
        .RESET_VEC   (RESET_VEC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .pc         (pc),
        .pcEnable   (pcEnable),
        .pcLoad     (pcLoad),
        .pcInAddr   (pcInAddr),
        .fetchReq   (fetchReq),
        .fetchAddr  (fetchAddr),
        .fetchAck   (fetchAck),
        .execDone   (execDone),
        .jmp        (jmp),
        .call       (call),
        .ret        (ret),
        .target     (target),
        .halted     (halted),
        .stackErr   (stackErr),
        .stackDepth (stackDepth)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Expected outputs for the current cycle
    always_comb begin
        exp_en    = 1'b0;
        exp_load  = 1'b0;
        exp_in    = 16'h0000;
        exp_req   = 1'b0;
        exp_faddr = 16'h0000;
        exp_halt  = 1'b0;
        if (m_phase == PH_BOOT) begin
            exp_load = 1'b1;
            exp_in   = RESET_VEC;
        end else if (m_phase == PH_FETCH) begin
            exp_req   = 1'b1;
            exp_faddr = m_pc;
            exp_en    = fetchAck;
        end else if (m_phase == PH_EXEC && execDone) begin
`ifdef RA8_PCSEQ_RETSTACK_EN
            if (ret) begin
                if (m_depth > 0) begin
                    exp_load = 1'b1;
                    exp_in   = m_stk[m_depth-1];
                end
            end else if (call) begin
                if (m_depth < STACK_DEPTH) begin
                    exp_load = 1'b1;
                    exp_in   = target;
                end
            end else if (jmp) begin
                exp_load = 1'b1;
                exp_in   = target;
            end
`else
            if (call || jmp) begin
                exp_load = 1'b1;
                exp_in   = target;
            end
`endif
        end else if (m_phase == PH_HALT) begin
            exp_halt = 1'b1;
        end
    end

    // Instruction-cycle progression and PC counter model
    always @(posedge clk) begin
        if (exp_load) m_pc <= exp_in;
        else if (exp_en) m_pc <= m_pc + 16'd1;
        if (reset) begin
            m_phase <= PH_BOOT;
            m_depth <= 0;
            m_err   <= 1'b0;
            m_valid <= 1'b1;
        end else begin
            case (m_phase)
                PH_BOOT:  m_phase <= PH_IDLE;
                PH_IDLE:  if (run) m_phase <= PH_FETCH;
                PH_FETCH: if (fetchAck) m_phase <= PH_EXEC;
                PH_EXEC: if (execDone) begin
                    m_phase <= run ? PH_FETCH : PH_IDLE;
`ifdef RA8_PCSEQ_RETSTACK_EN
                    if (ret) begin
                        if (m_depth == 0) begin
                            m_phase <= PH_HALT;
                            m_err   <= 1'b1;
                        end else begin
                            m_depth <= m_depth - 1;
                        end
                    end else if (call) begin
                        if (m_depth == STACK_DEPTH) begin
                            m_phase <= PH_HALT;
                            m_err   <= 1'b1;
                        end else begin
                            m_stk[m_depth] <= m_pc;
                            m_depth <= m_depth + 1;
                        end
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    // Compare process
    always @(negedge clk) begin
        if (m_valid) begin
            check("pcEnable", 32'(pcEnable), 32'(exp_en));
            check("pcLoad", 32'(pcLoad), 32'(exp_load));
            check("pcInAddr", 32'(pcInAddr), 32'(exp_in));
            check("fetchReq", 32'(fetchReq), 32'(exp_req));
            check("fetchAddr", 32'(fetchAddr), 32'(exp_faddr));
            check("halted", 32'(halted), 32'(exp_halt));
            check("stackErr", 32'(stackErr), 32'(m_err));
            check("stackDepth", 32'(stackDepth), 32'(m_depth));
        end
        if (pcEnable === 1'b1) en_total++;
        if (fetchReq === 1'b1) req_total++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fetch();
        for (int i = 0; i < 30 && m_phase != PH_FETCH; i++) tick();
        if (m_phase != PH_FETCH) begin
            checks++;
            errors++;
            $display("FAIL wait_fetch actual=timeout required=fetch at %0t", $time);
        end
    endtask

    task automatic instr(input int aw, input int dw, input logic j, input logic c,
                         input logic r, input logic [15:0] t,
                         output logic ld, output logic [15:0] ia);
        wait_fetch();
        fetchAck = 1'b0;
        repeat (aw) tick();
        fetchAck = 1'b1;
        tick();
        fetchAck = 1'b0;
        repeat (dw) tick();
        execDone = 1'b1;
        jmp = j;
        call = c;
        ret = r;
        target = t;
        #1;
        ld = pcLoad;
        ia = pcInAddr;
        tick();
        execDone = 1'b0;
        jmp = 1'b0;
        call = 1'b0;
        ret = 1'b0;
    endtask

    initial begin
        logic        ld;
        logic [15:0] ia;
        int          be, br;

        reset = 1'b1; run = 1'b0; fetchAck = 1'b0; execDone = 1'b0;
        jmp = 1'b0; call = 1'b0; ret = 1'b0; target = 16'h0000;
        tick();
        tick();
        check("boot_load", 32'(pcLoad), 32'd1);
        check("boot_inaddr", 32'(pcInAddr), 32'h0000);
        check("boot_fetchreq", 32'(fetchReq), 32'd0);
        check("boot_depth", 32'(stackDepth), 32'd0);

        // Five back-to-back minimum-length instructions
        reset = 1'b0;
        run = 1'b1;
        be = en_total;
        for (int k = 0; k < 5; k++) instr(0, 0, 1'b0, 1'b0, 1'b0, 16'h0000, ld, ia);
        wait_fetch();
        check("pc_after5", 32'(fetchAddr), 32'h0005);
        check("en_pulses5", 32'(en_total - be), 32'd5);

        // Fetch wait with run dropped mid-instruction
        instr(0, 0, 1'b1, 1'b0, 1'b0, 16'h0010, ld, ia);
        wait_fetch();
        check("wait_addr", 32'(fetchAddr), 32'h0010);
        be = en_total;
        br = req_total;
        run = 1'b0;
        repeat (3) tick();
        fetchAck = 1'b1;
        tick();
        fetchAck = 1'b0;
        execDone = 1'b1;
        tick();
        execDone = 1'b0;
        repeat (4) tick();
        check("wait_req_cycles", 32'(req_total - br), 32'd4);
        check("wait_en_pulses", 32'(en_total - be), 32'd1);
        check("idle_no_req", 32'(fetchReq), 32'd0);

        // Jump
        run = 1'b1;
        instr(0, 1, 1'b1, 1'b0, 1'b0, 16'h00F0, ld, ia);
        check("jmp_load", 32'(ld), 32'd1);
        check("jmp_inaddr", 32'(ia), 32'h00F0);
        wait_fetch();
        check("jmp_fetchaddr", 32'(fetchAddr), 32'h00F0);

`ifdef RA8_PCSEQ_RETSTACK_EN
        instr(0, 0, 1'b1, 1'b0, 1'b0, 16'h0020, ld, ia);
        instr(1, 0, 1'b0, 1'b1, 1'b0, 16'h0100, ld, ia);
        check("call_inaddr", 32'(ia), 32'h0100);
        check("call_depth", 32'(stackDepth), 32'd1);
        instr(0, 0, 1'b0, 1'b0, 1'b1, 16'h0000, ld, ia);
        check("ret_load", 32'(ld), 32'd1);
        check("ret_inaddr", 32'(ia), 32'h0021);
        check("ret_depth", 32'(stackDepth), 32'd0);
        instr(0, 0, 1'b0, 1'b1, 1'b0, 16'h0300, ld, ia);
        instr(0, 0, 1'b1, 1'b1, 1'b1, 16'h0200, ld, ia);
        check("prio_ret_inaddr", 32'(ia), 32'h0022);
        check("prio_depth", 32'(stackDepth), 32'd0);

        // Overflow on the fifth nested call
        for (int k = 0; k < 4; k++) instr(0, 0, 1'b0, 1'b1, 1'b0, 16'(16'h0400 + k * 16), ld, ia);
        check("nest_depth", 32'(stackDepth), 32'd4);
        instr(0, 0, 1'b0, 1'b1, 1'b0, 16'h0500, ld, ia);
        check("ovf_noload", 32'(ld), 32'd0);
        check("ovf_halted", 32'(halted), 32'd1);
        check("ovf_err", 32'(stackErr), 32'd1);
        repeat (5) tick();
        check("ovf_stays_halted", 32'(halted), 32'd1);
        reset = 1'b1;
        tick();
        check("rst_halt_boot", 32'(pcLoad), 32'd1);
        check("rst_halt_depth", 32'(stackDepth), 32'd0);
        check("rst_halt_err", 32'(stackErr), 32'd0);
        reset = 1'b0;

        // Underflow
        instr(0, 0, 1'b0, 1'b0, 1'b1, 16'h0000, ld, ia);
        check("unf_noload", 32'(ld), 32'd0);
        check("unf_halted", 32'(halted), 32'd1);
        check("unf_err", 32'(stackErr), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Reset mid-fetch and mid-execute
        wait_fetch();
        reset = 1'b1;
        tick();
        check("rst_fetch_boot", 32'(pcLoad), 32'd1);
        check("rst_fetch_req", 32'(fetchReq), 32'd0);
        reset = 1'b0;
        instr(0, 0, 1'b0, 1'b1, 1'b0, 16'h0600, ld, ia);
        wait_fetch();
        fetchAck = 1'b1;
        tick();
        fetchAck = 1'b0;
        reset = 1'b1;
        tick();
        check("rst_exec_boot", 32'(pcLoad), 32'd1);
        check("rst_exec_depth", 32'(stackDepth), 32'd0);
        reset = 1'b0;
`else
        instr(0, 0, 1'b0, 1'b1, 1'b0, 16'h0100, ld, ia);
        check("call_as_jmp_load", 32'(ld), 32'd1);
        check("call_as_jmp_inaddr", 32'(ia), 32'h0100);
        instr(0, 0, 1'b0, 1'b0, 1'b1, 16'h0000, ld, ia);
        check("ret_noop", 32'(ld), 32'd0);
        check("nostack_err", 32'(stackErr), 32'd0);
        check("nostack_halted", 32'(halted), 32'd0);
        wait_fetch();
        reset = 1'b1;
        tick();
        check("rst_fetch_boot", 32'(pcLoad), 32'd1);
        reset = 1'b0;
`endif

        // Randomized traffic, checked every cycle by the compare process
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 149) == 0);
            run      = ($urandom_range(0, 9) != 0);
            fetchAck = 1'($urandom_range(0, 1));
            execDone = 1'($urandom_range(0, 1));
            jmp      = ($urandom_range(0, 3) == 0);
            call     = ($urandom_range(0, 3) == 0);
            ret      = ($urandom_range(0, 7) == 0);
            target   = 16'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
